// File: rtl/ccr_unit.sv
// Condition-code register with branch evaluation and optional interrupt save/restore.
// Define CCR_SAVE_EN to enable the IDLE/SAVE/ISR/RESTORE context-save state machine.
module ccr_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_en,
  input  logic [3:0] alu_op,
  input  logic       c_in,
  input  logic       n_in,
  input  logic       z_in,
  input  logic       stall,
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic       int_req,
  input  logic       rti,
  output logic [2:0] flags_old,
  output logic       br_taken,
  output logic       in_isr,
  output logic       nest_err
);

  localparam int unsigned FLAG_W = 3;
  localparam int unsigned OP_W   = 4;
  localparam logic [OP_W-1:0] OP_LAST_WR = OP_W'(4'b1011);

  localparam logic [1:0] BR_JZ  = 2'b00;
  localparam logic [1:0] BR_JN  = 2'b01;
  localparam logic [1:0] BR_JC  = 2'b10;

  logic [FLAG_W-1:0] ccr_q;
  logic [FLAG_W-1:0] ccr_d;
  logic              sel_flag;

  assign flags_old = ccr_q;

  // Branch decision uses the registered CCR only (no bypass from ALU flags)
  always_comb begin
    sel_flag = 1'b1;
    case (br_type)
      BR_JZ:   sel_flag = ccr_q[0];
      BR_JN:   sel_flag = ccr_q[1];
      BR_JC:   sel_flag = ccr_q[2];
      default: sel_flag = 1'b1;
    endcase
    br_taken = br_valid & sel_flag;
  end

  // ALU write first, then the taken-branch clear wins on the tested bit
  always_comb begin
    ccr_d = ccr_q;
    if (alu_en && (alu_op <= OP_LAST_WR)) begin
      ccr_d = {c_in, n_in, z_in};
    end
    if (br_taken) begin
      case (br_type)
        BR_JZ:   ccr_d[0] = 1'b0;
        BR_JN:   ccr_d[1] = 1'b0;
        BR_JC:   ccr_d[2] = 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CCR_SAVE_EN
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SAVE    = 2'b01,
    ISR     = 2'b10,
    RESTORE = 2'b11
  } state_t;

  state_t            state_q;
  logic [FLAG_W-1:0] saved_q;
  logic              in_isr_q;
  logic              nest_err_q;

  assign in_isr   = in_isr_q;
  assign nest_err = nest_err_q;

  // A restore on the rti edge overrides the normal CCR update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q      <= '0;
      saved_q    <= '0;
      state_q    <= IDLE;
      in_isr_q   <= 1'b0;
      nest_err_q <= 1'b0;
    end else if (!stall) begin
      ccr_q <= ccr_d;
      case (state_q)
        IDLE: begin
          if (rti) nest_err_q <= 1'b1;
          if (int_req) begin
            state_q  <= SAVE;
            saved_q  <= ccr_q;
            in_isr_q <= 1'b1;
          end
        end
        SAVE: begin
          if (rti) nest_err_q <= 1'b1;
          state_q <= ISR;
        end
        ISR: begin
          if (int_req) nest_err_q <= 1'b1;
          if (rti) begin
            state_q  <= RESTORE;
            ccr_q    <= saved_q;
            in_isr_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          in_isr_q <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_save_in;
  assign unused_save_in = int_req ^ rti;

  assign in_isr   = 1'b0;
  assign nest_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q <= '0;
    end else if (!stall) begin
      ccr_q <= ccr_d;
    end
  end
`endif

endmodule

// File: tb/tb_ccr_unit.sv
// Scoreboard bench for ccr_unit: stimulus pushes model expectations, a monitor pops and compares.
module tb_ccr_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_en = 1'b0;
  logic [3:0] alu_op = 4'd0;
  logic       c_in = 1'b0;
  logic       n_in = 1'b0;
  logic       z_in = 1'b0;
  logic       stall = 1'b0;
  logic       br_valid = 1'b0;
  logic [1:0] br_type = 2'd0;
  logic       int_req = 1'b0;
  logic       rti = 1'b0;
  logic [2:0] flags_old;
  logic       br_taken;
  logic       in_isr;
  logic       nest_err;

  always #5 clk = ~clk;

  ccr_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_en   (alu_en),
    .alu_op   (alu_op),
    .c_in     (c_in),
    .n_in     (n_in),
    .z_in     (z_in),
    .stall    (stall),
    .br_valid (br_valid),
    .br_type  (br_type),
    .int_req  (int_req),
    .rti      (rti),
    .flags_old(flags_old),
    .br_taken (br_taken),
    .in_isr   (in_isr),
    .nest_err (nest_err)
  );

  typedef struct {
    logic       bt;
    logic [2:0] flags;
    logic       isr;
    logic       nerr;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  // Reference model: flags, saved copy, interrupt phase (0 idle,1 save,2 isr,3 restore), sticky error
  logic [2:0] m_ccr = 3'd0;
  logic [2:0] m_saved = 3'd0;
  int         m_phase = 0;
  logic       m_nerr = 1'b0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic en, input logic [3:0] op, input logic [2:0] cnz,
                     input logic st, input logic bv, input logic [1:0] bt,
                     input logic ir, input logic rt);
    exp_t       e;
    int         idx;
    logic       tk;
    logic [2:0] nxt;
    @(negedge clk);
    alu_en = en; alu_op = op; {c_in, n_in, z_in} = cnz;
    stall = st; br_valid = bv; br_type = bt; int_req = ir; rti = rt;
    idx = (bt == 2'd0) ? 0 : (bt == 2'd1) ? 1 : 2;
    tk  = bv && (bt == 2'd3 || m_ccr[idx]);
    e.bt = tk;
    if (!st) begin
      nxt = m_ccr;
      if (en && op < 4'd12) nxt = cnz;
      if (tk && bt != 2'd3) nxt[idx] = 1'b0;
`ifdef CCR_SAVE_EN
      case (m_phase)
        0: begin
          if (rt) m_nerr = 1'b1;
          if (ir) begin m_saved = m_ccr; m_phase = 1; end
        end
        1: begin
          if (rt) m_nerr = 1'b1;
          m_phase = 2;
        end
        2: begin
          if (ir) m_nerr = 1'b1;
          if (rt) begin nxt = m_saved; m_phase = 3; end
        end
        default: m_phase = 0;
      endcase
`endif
      m_ccr = nxt;
    end
    e.flags = m_ccr;
    e.isr   = (m_phase == 1 || m_phase == 2);
    e.nerr  = m_nerr;
    #1 q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied away from any clock edge; checked before the next edge
  task automatic do_reset(input logic bv, input logic [1:0] bt);
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
    #3;
    br_valid = bv; br_type = bt; alu_en = 1'b0; int_req = 1'b0; rti = 1'b0; stall = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_flags", flags_old, 3'd0);
    check("rst_in_isr", {2'b0, in_isr}, 3'd0);
    check("rst_nest_err", {2'b0, nest_err}, 3'd0);
    check("rst_br_taken", {2'b0, br_taken}, {2'b0, (bv && bt == 2'd3)});
    m_ccr = 3'd0; m_saved = 3'd0; m_phase = 0; m_nerr = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Monitor: compare br_taken during the cycle, registered outputs just after the edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        me = q.pop_front();
        check("br_taken", {2'b0, br_taken}, {2'b0, me.bt});
        @(posedge clk);
        #1;
        check("flags_old", flags_old, me.flags);
        check("in_isr", {2'b0, in_isr}, {2'b0, me.isr});
        check("nest_err", {2'b0, nest_err}, {2'b0, me.nerr});
      end
    end
  end

  initial begin
    logic       r_en, r_st, r_bv, r_ir, r_rt;
    logic [3:0] r_op;
    logic [2:0] r_cnz;
    logic [1:0] r_bt;
    int         n;

    do_reset(1'b1, 2'd3);

    // ALU write, then OUT op leaves flags alone
    cyc(1'b1, 4'd2, 3'b101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd12, 3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd15, 3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

    // JZ taken clears Z, repeat is not taken
    cyc(1'b1, 4'd2, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);

    // JC clear beats simultaneous ALU write on bit C
    cyc(1'b1, 4'd2, 3'b100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd2, 3'b111, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    idle();

    // Interrupt save, ALU write in ISR, restore on rti
    cyc(1'b1, 4'd0, 3'b110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    cyc(1'b1, 4'd3, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd4, 3'b011, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
    idle();
    idle();

    // Nested interrupt and stray rti set the sticky error
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    cyc(1'b1, 4'd1, 3'b010, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle();
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle();
    idle();
    do_reset(1'b1, 2'd0);

    // Stall freezes state while br_taken still evaluates; reset mid-ISR drops the save
    cyc(1'b1, 4'd2, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, 4'd2, 3'b111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc(1'b1, 4'd2, 3'b101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle();
    cyc(1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    idle();
    do_reset(1'b0, 2'd3);
    idle();
    cyc(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    idle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      r_en  = ($urandom_range(0, 1) == 0);
      r_op  = 4'($urandom_range(0, 15));
      r_cnz = 3'($urandom_range(0, 7));
      r_st  = ($urandom_range(0, 7) == 0);
      r_bv  = ($urandom_range(0, 2) == 0);
      r_bt  = 2'($urandom_range(0, 3));
      r_ir  = ($urandom_range(0, 15) == 0);
      r_rt  = ($urandom_range(0, 15) == 0);
      cyc(r_en, r_op, r_cnz, r_st, r_bv, r_bt, r_ir, r_rt);
      if (i % 700 == 699) do_reset(r_bv, r_bt);
    end

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL final_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
CCR_UNIT -- requirements
Module: ccr_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 alu_en  in  1  ALU result and flags valid this cycle.
REQ-005 alu_op  in  4  ALU function code: INC=0000 ... SHR=1001, SETC=1010, CLC=1011, OUT=1100.
REQ-006 c_in, n_in, z_in  in  1 each  ALU CarryOut, NegativeFlag, ZeroFlag.
REQ-007 stall  in  1  freeze all state; outputs hold.
REQ-008 br_valid  in  1  conditional/unconditional branch in execute this cycle.
REQ-009 br_type  in  2  00 JZ, 01 JN, 10 JC, 11 JMP.
REQ-010 int_req  in  1  single-cycle interrupt entry pulse.
REQ-011 rti  in  1  single-cycle return-from-interrupt pulse.
REQ-012 flags_old  out  3  current CCR {C,N,Z}: bit2 C, bit1 N, bit0 Z; fed back to the ALU.
REQ-013 br_taken  out  1  combinational: br_valid and (selected flag set, or br_type=11).
REQ-014 in_isr  out  1  high while interrupt state machine is in ISR.
REQ-015 nest_err  out  1  sticky error flag.

Function
REQ-016 CCR SHALL load {c_in,n_in,z_in} on a clock edge when alu_en=1, stall=0 and alu_op is 0000-1011; alu_op 1100-1111 SHALL leave the CCR unchanged.
REQ-017 On a taken JZ/JN/JC (stall=0), the tested flag SHALL clear on the following edge; JMP SHALL change no flag.
REQ-018 If the ALU write and a taken-branch clear hit the same edge, the clear SHALL win for the tested bit; the other two bits take the ALU values.
REQ-019 br_taken SHALL use the CCR contents before that edge; there is no same-cycle bypass from c_in/n_in/z_in.
REQ-020 State machine states: IDLE, SAVE, ISR, RESTORE.
REQ-021 IDLE: int_req=1 -> SAVE; the CCR is copied into saved_ccr on the same edge.
REQ-022 SAVE: next edge -> ISR unconditionally; the CCR is unchanged by this transition.
REQ-023 ISR: rti=1 -> RESTORE; int_req=1 while in ISR SHALL set nest_err, be otherwise ignored, and leave saved_ccr unchanged.
REQ-024 RESTORE: the CCR is loaded from saved_ccr on entry and the state returns to IDLE on the next edge. The restore overrides any ALU write or branch clear on that same edge.
REQ-025 rti in IDLE or SAVE SHALL set nest_err and SHALL NOT change state.
REQ-026 stall=1 SHALL hold the CCR, saved_ccr, state and nest_err. br_taken still evaluates.
REQ-027 in_isr SHALL be 1 exactly in SAVE and ISR.
REQ-028 Restore latency: the flags from the rti edge are visible on flags_old one cycle after rti is sampled.

Reset
REQ-029 rst_n low SHALL immediately force: CCR=000, saved_ccr=000, state=IDLE, in_isr=0, nest_err=0. br_taken then follows br_valid and br_type=11 only.
REQ-030 Reset asserted mid-ISR SHALL discard saved_ccr; no restore occurs after release.
REQ-031 nest_err SHALL clear only by reset.

Configuration
REQ-032 Macro CCR_SAVE_EN: when defined, REQ-020 to REQ-025 and REQ-030 apply.
REQ-033 When CCR_SAVE_EN is undefined, int_req and rti SHALL be ignored, there SHALL be no saved_ccr storage, and in_isr and nest_err SHALL tie to 0. All other behaviour is identical.

Verification
REQ-034 Scenario 1: reset; alu_en=1, alu_op=0010, {c,n,z}=101 -> flags_old=101 next cycle; then alu_op=1100, {c,n,z}=010 -> flags_old stays 101.
REQ-035 Scenario 2: CCR=001, br_valid=1, br_type=00 -> br_taken=1, flags_old=000 next cycle; repeat -> br_taken=0.
REQ-036 Scenario 3: CCR=100, JC and ALU write of 111 on the same edge -> flags_old=011.
REQ-037 Scenario 4 (CCR_SAVE_EN): CCR=110, int_req pulse -> in_isr=1 for SAVE+ISR; ALU writes 001; rti -> flags_old=110 one cycle after rti, in_isr=0, state IDLE.
REQ-038 Scenario 5: int_req in ISR, or rti in IDLE -> nest_err=1, saved_ccr/state unchanged; nest_err persists until rst_n=0.
REQ-039 Scenario 6: stall=1 with alu_en=1, {c,n,z}=111 and a taken JZ -> flags_old unchanged and br_taken=1; rst_n low mid-ISR -> flags_old=000, in_isr=0 with no clock edge.
